path_addr_gen: RTL and testbench



---
 rtl/path_addr_gen_pkg.sv | 21 ++
 rtl/path_bucket_index.sv | 29 ++
 rtl/path_addr_gen.sv | 185 ++++++++++++++++++
 tb/tb_path_addr_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/path_addr_gen_pkg.sv
// Shared definitions for the path address generator: DDR3 command encodings,
// default tree/bucket geometry and the generator state type.
package path_addr_gen_pkg;

   localparam int unsigned DDRCWidth             = 3;
   localparam logic [DDRCWidth-1:0] DDR3CMD_Write = 3'd0;
   localparam logic [DDRCWidth-1:0] DDR3CMD_Read  = 3'd1;

   localparam int unsigned ORAML_Default          = 10;
   localparam int unsigned BktSize_Default        = 8;
   localparam int unsigned BktHSize_Default       = 1;
   localparam int unsigned DDRAWidth_Default      = 27;

   localparam int unsigned STWidth = 1;

   typedef enum logic [STWidth-1:0] {
      ST_Idle  = 1'b0,
      ST_Issue = 1'b1
   } addrgen_state_t;

endpackage

// File: rtl/path_bucket_index.sv
// Combinational bucket index for one level of a root-to-leaf path:
// idx = (2^level - 1) + (leaf >> (ORAML - level)), ORAML+1 bits wide.
module path_bucket_index
   import path_addr_gen_pkg::*;
#(
   parameter int unsigned ORAML = ORAML_Default,
   parameter int unsigned LVW   = $clog2(ORAML_Default + 1)
) (
   input  logic [ORAML-1:0] i_leaf,
   input  logic [LVW-1:0]   i_level,
   output logic [ORAML:0]   o_idx
);

   logic [ORAML:0] w_leaf_ext;
   logic [ORAML:0] w_one;
   logic [ORAML:0] w_level_base;
   logic [ORAML:0] w_level_offs;
   logic [LVW-1:0] w_shift;

   always_comb begin
      w_leaf_ext   = {1'b0, i_leaf};
      w_one        = {{ORAML{1'b0}}, 1'b1};
      w_shift      = LVW'(ORAML) - i_level;
      w_level_base = (w_one << i_level) - w_one;
      w_level_offs = w_leaf_ext >> w_shift;
      o_idx        = w_level_base + w_level_offs;
   end

endmodule

// File: rtl/path_addr_gen.sv
// Streams one DRAM burst command per bucket burst along an ORAM tree path.
// Define ADDRGEN_OUTREG_EN to drive the DRAM command port from a 2-entry skid buffer.
module path_addr_gen
   import path_addr_gen_pkg::*;
#(
   parameter int unsigned ORAML             = ORAML_Default,
   parameter int unsigned BktSize_DRBursts  = BktSize_Default,
   parameter int unsigned BktHSize_DRBursts = BktHSize_Default,
   parameter int unsigned DDRAWidth         = DDRAWidth_Default,
   parameter int unsigned BaseAddr          = 0
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic [ORAML-1:0]     AddrGenLeaf,
   input  logic                 AddrGenRead,
   input  logic                 AddrGenHeader,
   input  logic                 AddrGenInValid,
   output logic                 AddrGenInReady,
   output logic [DDRAWidth-1:0] DRAMAddress,
   output logic [DDRCWidth-1:0] DRAMCommand,
   output logic                 DRAMCommandValid,
   input  logic                 DRAMCommandReady,
   output logic                 AddrTransfer,
   output logic                 PathDone
);

   localparam int unsigned LVW = $clog2(ORAML + 1);
   localparam int unsigned BW  = $clog2(BktSize_DRBursts + 1);

   addrgen_state_t r_state, w_state_nxt;

   logic [ORAML-1:0]     r_leaf;
   logic                 r_read;
   logic                 r_header;
   logic [LVW-1:0]       r_level;
   logic [BW-1:0]        r_burst;

   logic [BW-1:0]        w_burst_last;
   logic [LVW-1:0]       w_level_last;
   logic [ORAML:0]       w_idx;
   logic [DDRAWidth-1:0] w_gen_addr;
   logic                 w_accept;
   logic                 w_bkt_end;
   logic                 w_gen_last;
   logic                 w_gen_valid;
   logic                 w_gen_adv;
   logic                 w_path_end;

   path_bucket_index #(
      .ORAML (ORAML),
      .LVW   (LVW)
   ) u_bucket_index (
      .i_leaf  (r_leaf),
      .i_level (r_level),
      .o_idx   (w_idx)
   );

   assign AddrGenInReady = (r_state == ST_Idle);
   assign w_accept       = AddrGenInValid & AddrGenInReady;
   assign DRAMCommand    = r_read ? DDR3CMD_Read : DDR3CMD_Write;

   always_comb begin
      w_burst_last = r_header ? BW'(BktHSize_DRBursts - 1) : BW'(BktSize_DRBursts - 1);
      w_level_last = r_read ? LVW'(ORAML) : '0;
      w_bkt_end    = (r_burst == w_burst_last);
      w_gen_last   = w_bkt_end & (r_level == w_level_last);
      w_gen_addr   = DDRAWidth'(BaseAddr)
                   + DDRAWidth'(w_idx) * DDRAWidth'(BktSize_DRBursts)
                   + DDRAWidth'(r_burst);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_leaf   <= '0;
         r_read   <= 1'b0;
         r_header <= 1'b0;
         r_level  <= '0;
         r_burst  <= '0;
      end else if (w_accept) begin
         r_leaf   <= AddrGenLeaf;
         r_read   <= AddrGenRead;
         r_header <= AddrGenHeader;
         r_level  <= AddrGenRead ? '0 : LVW'(ORAML);
         r_burst  <= '0;
      end else if (w_gen_adv) begin
         if (w_bkt_end) begin
            r_burst <= '0;
            if (!w_gen_last)
               r_level <= r_read ? r_level + LVW'(1) : r_level - LVW'(1);
         end else begin
            r_burst <= r_burst + BW'(1);
         end
      end
   end

`ifdef ADDRGEN_OUTREG_EN
   // Generator pushes into a 2-entry buffer; each entry carries its own last-of-path flag.
   logic                 r_gen_done;
   logic [1:0]           r_cnt;
   logic [DDRAWidth-1:0] r_q_addr [2];
   logic [1:0]           r_q_last;
   logic                 w_push;
   logic                 w_pop;

   always_comb begin
      w_gen_valid      = (r_state == ST_Issue) & ~r_gen_done;
      w_push           = w_gen_valid & (r_cnt != 2'd2);
      w_gen_adv        = w_push;
      DRAMCommandValid = (r_cnt != 2'd0);
      DRAMAddress      = r_q_addr[0];
      w_pop            = DRAMCommandValid & DRAMCommandReady;
      AddrTransfer     = w_pop;
      PathDone         = w_pop & r_q_last[0];
      w_path_end       = PathDone;
   end

   always_ff @(posedge Clock) begin
      if (Reset)
         r_gen_done <= 1'b0;
      else if (w_accept)
         r_gen_done <= 1'b0;
      else if (w_push & w_gen_last)
         r_gen_done <= 1'b1;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_cnt       <= '0;
         r_q_addr[0] <= '0;
         r_q_addr[1] <= '0;
         r_q_last    <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_cnt == 2'd0) begin
                  r_q_addr[0] <= w_gen_addr;
                  r_q_last[0] <= w_gen_last;
               end else begin
                  r_q_addr[1] <= w_gen_addr;
                  r_q_last[1] <= w_gen_last;
               end
               r_cnt <= r_cnt + 2'd1;
            end
            2'b01: begin
               r_q_addr[0] <= r_q_addr[1];
               r_q_last[0] <= r_q_last[1];
               r_cnt       <= r_cnt - 2'd1;
            end
            2'b11: begin
               r_q_addr[0] <= w_gen_addr;
               r_q_last[0] <= w_gen_last;
            end
            default: ;
         endcase
      end
   end
`else
   always_comb begin
      w_gen_valid      = (r_state == ST_Issue);
      DRAMCommandValid = w_gen_valid;
      DRAMAddress      = w_gen_addr;
      w_gen_adv        = w_gen_valid & DRAMCommandReady;
      AddrTransfer     = w_gen_adv;
      PathDone         = w_gen_adv & w_gen_last;
      w_path_end       = PathDone;
   end
`endif

   always_ff @(posedge Clock) begin
      if (Reset)
         r_state <= ST_Idle;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_Idle:  if (w_accept)   w_state_nxt = ST_Issue;
         ST_Issue: if (w_path_end) w_state_nxt = ST_Idle;
         default:  w_state_nxt = ST_Idle;
      endcase
   end

endmodule

// File: tb/tb_path_addr_gen.sv
// Directed, table-driven bench for path_addr_gen at ORAML=2, 2-burst buckets, 1-burst headers.
// Honours ADDRGEN_OUTREG_EN for the expected start latency.
module tb_path_addr_gen;

`ifdef ADDRGEN_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   localparam logic [2:0] CMD_RD = 3'd1;
   localparam logic [2:0] CMD_WR = 3'd0;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [1:0]  AddrGenLeaf;
   logic        AddrGenRead;
   logic        AddrGenHeader;
   logic        AddrGenInValid;
   logic        AddrGenInReady;
   logic [26:0] DRAMAddress;
   logic [2:0]  DRAMCommand;
   logic        DRAMCommandValid;
   logic        DRAMCommandReady;
   logic        AddrTransfer;
   logic        PathDone;

   int n_checks = 0;
   int n_fail   = 0;

   path_addr_gen #(
      .ORAML             (2),
      .BktSize_DRBursts  (2),
      .BktHSize_DRBursts (1),
      .DDRAWidth         (27),
      .BaseAddr          (0)
   ) dut (
      .Clock            (Clock),
      .Reset            (Reset),
      .AddrGenLeaf      (AddrGenLeaf),
      .AddrGenRead      (AddrGenRead),
      .AddrGenHeader    (AddrGenHeader),
      .AddrGenInValid   (AddrGenInValid),
      .AddrGenInReady   (AddrGenInReady),
      .DRAMAddress      (DRAMAddress),
      .DRAMCommand      (DRAMCommand),
      .DRAMCommandValid (DRAMCommandValid),
      .DRAMCommandReady (DRAMCommandReady),
      .AddrTransfer     (AddrTransfer),
      .PathDone         (PathDone)
   );

   always #5 Clock = ~Clock;

   typedef struct packed {
      bit [1:0]       leaf;
      bit             rd;
      bit             hdr;
      int unsigned    n;
      bit [5:0][31:0] exp;
      int unsigned    stall_addr;
      int unsigned    stall_n;
      bit             toggle;
   } vec_t;

   function automatic vec_t mk(bit [1:0] leaf, bit rd, bit hdr, int unsigned n,
                               int unsigned a0, int unsigned a1, int unsigned a2,
                               int unsigned a3, int unsigned a4, int unsigned a5,
                               int unsigned sa, int unsigned sn, bit tog);
      vec_t v;
      v.leaf = leaf; v.rd = rd; v.hdr = hdr; v.n = n;
      v.exp[0] = a0; v.exp[1] = a1; v.exp[2] = a2;
      v.exp[3] = a3; v.exp[4] = a4; v.exp[5] = a5;
      v.stall_addr = sa; v.stall_n = sn; v.toggle = tog;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after the last transfer.
   task automatic run_path(input vec_t v, input int id);
      int unsigned got, cyc, hold, stall_left;
      logic        rdy;
      logic [2:0]  exp_cmd;
      got = 0; cyc = 0; hold = 0; stall_left = v.stall_n;
      exp_cmd = v.rd ? CMD_RD : CMD_WR;
      DRAMCommandReady = 1'b1;
      #1;
      check($sformatf("v%0d_inready_idle", id), 32'(AddrGenInReady), 1);
      AddrGenLeaf = v.leaf; AddrGenRead = v.rd; AddrGenHeader = v.hdr; AddrGenInValid = 1'b1;
      @(negedge Clock);
      AddrGenInValid = 1'b0;
      if (LAT == 2) begin
         #1;
         check($sformatf("v%0d_latency_gap", id), 32'(DRAMCommandValid), 0);
         @(negedge Clock);
      end
      #1;
      check($sformatf("v%0d_first_valid", id), 32'(DRAMCommandValid), 1);
      while (got < v.n && cyc < 40) begin
         if (v.toggle) begin
            AddrGenInValid = cyc[0];
            AddrGenLeaf    = 2'(cyc);
            AddrGenRead    = ~v.rd;
         end
         rdy = 1'b1;
         if (DRAMCommandValid && DRAMAddress == 27'(v.stall_addr)) begin
            hold++;
            if (stall_left > 0) begin
               rdy = 1'b0;
               stall_left--;
            end
         end
         DRAMCommandReady = rdy;
         #1;
         check($sformatf("v%0d_inready_busy", id), 32'(AddrGenInReady), 0);
         if (DRAMCommandValid && rdy) begin
            check($sformatf("v%0d_addr%0d", id, got), 32'(DRAMAddress), v.exp[got]);
            check($sformatf("v%0d_cmd%0d", id, got), 32'(DRAMCommand), 32'(exp_cmd));
            check($sformatf("v%0d_xfer%0d", id, got), 32'(AddrTransfer), 1);
            check($sformatf("v%0d_done%0d", id, got), 32'(PathDone), 32'(got == v.n - 1));
            got++;
         end else begin
            check($sformatf("v%0d_idle_xfer", id), 32'(AddrTransfer), 0);
            check($sformatf("v%0d_idle_done", id), 32'(PathDone), 0);
         end
         @(negedge Clock);
         cyc++;
      end
      AddrGenInValid = 1'b0;
      DRAMCommandReady = 1'b1;
      check($sformatf("v%0d_transfer_count", id), got, v.n);
      if (v.stall_n > 0)
         check($sformatf("v%0d_hold_cycles", id), hold, v.stall_n + 1);
      #1;
      check($sformatf("v%0d_inready_after", id), 32'(AddrGenInReady), 1);
      check($sformatf("v%0d_valid_after", id), 32'(DRAMCommandValid), 0);
   endtask

   vec_t vecs [7];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = mk(2'b10, 1, 0, 6,  0,  1,  4,  5, 10, 11, 999, 0, 0);
      vecs[1] = mk(2'b11, 0, 0, 6, 12, 13,  4,  5,  0,  1, 999, 0, 0);
      vecs[2] = mk(2'b10, 1, 1, 3,  0,  4, 10,  0,  0,  0, 999, 0, 0);
      vecs[3] = mk(2'b01, 0, 1, 3,  8,  2,  0,  0,  0,  0, 999, 0, 0);
      vecs[4] = mk(2'b00, 1, 0, 6,  0,  1,  2,  3,  6,  7,   2, 3, 0);
      vecs[5] = mk(2'b10, 1, 0, 6,  0,  1,  4,  5, 10, 11, 999, 0, 1);
      vecs[6] = mk(2'b00, 0, 0, 6,  6,  7,  2,  3,  0,  1, 999, 0, 0);

      Reset = 1'b1;
      AddrGenLeaf = '0; AddrGenRead = 1'b0; AddrGenHeader = 1'b0; AddrGenInValid = 1'b0;
      DRAMCommandReady = 1'b1;
      repeat (3) @(negedge Clock);
      #1;
      check("reset_inready", 32'(AddrGenInReady), 1);
      check("reset_valid", 32'(DRAMCommandValid), 0);
      check("reset_xfer", 32'(AddrTransfer), 0);
      check("reset_done", 32'(PathDone), 0);
      Reset = 1'b0;
      @(negedge Clock);

      for (int i = 0; i < 7; i++)
         run_path(vecs[i], i);

      // Reset lands after the third transfer of a read path; the next path starts clean.
      @(negedge Clock);
      AddrGenLeaf = 2'b10; AddrGenRead = 1'b1; AddrGenHeader = 1'b0; AddrGenInValid = 1'b1;
      @(negedge Clock);
      AddrGenInValid = 1'b0;
      if (LAT == 2) @(negedge Clock);
      begin
         int unsigned rexp [3];
         rexp[0] = 0; rexp[1] = 1; rexp[2] = 4;
         for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("rst_pre_valid%0d", k), 32'(DRAMCommandValid), 1);
            check($sformatf("rst_pre_addr%0d", k), 32'(DRAMAddress), rexp[k]);
            @(negedge Clock);
         end
      end
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      #1;
      check("rst_mid_valid", 32'(DRAMCommandValid), 0);
      check("rst_mid_xfer", 32'(AddrTransfer), 0);
      check("rst_mid_inready", 32'(AddrGenInReady), 1);
      @(negedge Clock);
      run_path(mk(2'b01, 1, 0, 6, 0, 1, 2, 3, 8, 9, 999, 0, 0), 7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
